mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
Shares the single data-memory port between two requesters: instruction fetch (read-only) and the memory-access stage (load/store).
- Grants at most one request per cycle.
- Tracks the one outstanding read and routes its response back to the requester that issued it.
- Data side has fixed priority, with a starvation guard that forces a fetch grant after STARVE_MAX consecutive losses.
- Sits between the pipeline front/back ends and the memory macro; the memory-access stage connects to the dm_* side.

Parameters:
XLEN, 32, address/data width (from `XLEN)
STARVE_MAX, 4, consecutive fetch losses before a fetch grant is forced (1..15)

Ports:
clk_i  in  1  system clock
resetn_i  in  1  reset; asynchronous, active-low
halt_i  in  1  halt; blocks new grants
if_req_i  in  1  fetch read request, held until granted
if_addr_i  in  XLEN  fetch address
if_gnt_o  out  1  fetch request issued this cycle
if_rdata_o  out  XLEN  fetch read data
if_rvalid_o  out  1  if_rdata_o valid
dm_req_i  in  1  data request, held until granted
dm_we_i  in  1  1 = store, 0 = load
dm_addr_i  in  XLEN  data address
dm_wdata_i  in  XLEN  store data
dm_gnt_o  out  1  data request issued this cycle
dm_rdata_o  out  XLEN  load data
dm_rvalid_o  out  1  dm_rdata_o valid
mem_ready_i  in  1  memory accepts a request this cycle
mem_addr_o  out  XLEN  memory address
mem_read_en_o  out  1  memory read strobe
mem_write_en_o  out  1  memory write strobe
mem_write_data_o  out  XLEN  memory write data
mem_read_data_i  in  XLEN  memory read data; valid 1 cycle after mem_read_en_o

Behaviour:
- Reset (async, resetn_i low): state=IDLE, owner=NONE, starve_cnt=0, arb_en=0.
  - All outputs 0 immediately.
  - arb_en sets on the first clk_i edge after resetn_i rises; no grant while arb_en=0.
- Issue condition: issue_ok = arb_en & !halt_i & mem_ready_i.
- Winner selection (combinational, same cycle as request):
  - Force fetch if if_req_i & starve_cnt==STARVE_MAX.
  - Otherwise data if dm_req_i.
  - Otherwise fetch if if_req_i.
  - Grant only when issue_ok.
- Memory outputs (combinational):
  - Carry the winner's addr/wdata and strobes.
  - mem_read_en_o = fetch grant | (data grant & !dm_we_i).
  - mem_write_en_o = data grant & dm_we_i.
  - mem_addr_o and mem_write_data_o are 0 when no grant.
  - mem_write_data_o is 0 for reads.
- FSM states:
  - IDLE: no read outstanding.
  - RESP_IF: fetch read outstanding.
  - RESP_DM: load outstanding.
- FSM transitions, every edge:
  - Fetch grant -> RESP_IF.
  - Load grant -> RESP_DM.
  - Store grant or no grant -> IDLE.
  - The response of the previous read and a new issue may occur in the same cycle (fully pipelined, 1 req/cycle).
- Response delivery:
  - In RESP_IF: if_rvalid_o=1, if_rdata_o=mem_read_data_i.
  - In RESP_DM: dm_rvalid_o=1, dm_rdata_o=mem_read_data_i.
  - rdata outputs are 0 when their rvalid is 0.
  - Read latency is exactly 1 cycle from grant to rvalid.
  - Stores produce no rvalid.
- Starvation counter (width 4, registered):
  - Increments when if_req_i & !if_gnt_o & dm_gnt_o, saturating at STARVE_MAX.
  - Clears to 0 on if_gnt_o or when !if_req_i.
  - Holds otherwise (halt, mem_ready_i low).
- halt_i: no new grants, counter holds. An outstanding response still completes the next cycle and FSM goes to IDLE.
- mem_ready_i low: same as halt for issue. The outstanding response is unaffected.
- Both requests with counter below max: data wins, fetch waits with if_gnt_o=0.

Decomposition:
- Package mem_arb_pkg holds:
  - arb_state_t enum {IDLE, RESP_IF, RESP_DM}
  - arb_owner_t enum {OWN_NONE, OWN_IF, OWN_DM}
  - STARVE_CNT_W=4 constant
- Sub-module mem_arb_starve_ctr: saturating counter with inc/clr/hold and a "max" flag output.
- The top level holds the FSM, the winner mux and response routing.

Test Plan:
- Reset release: resetn_i 0->1 with if_req_i=1 held → no grant on the first edge; if_gnt_o=1 in the cycle after arb_en sets; if_rvalid_o=1 one cycle later with if_rdata_o=mem_read_data_i (0xDEADBEEF).
- Back-to-back: dm load 0x100 then fetch 0x40 in consecutive cycles → dm_rvalid_o at cycle 1 and if_rvalid_o at cycle 2, each with correct data and no cross-delivery.
- Starvation (STARVE_MAX=4): if_req_i and dm_req_i both held high → dm_gnt_o for 4 cycles, if_gnt_o on the 5th, counter back to 0, dm wins again on the 6th.
- Store: dm_we_i=1, addr 0x200, wdata 0x12345678 → mem_write_en_o=1 with that addr/data in the same cycle; no dm_rvalid_o; FSM in IDLE.
- Halt/ready: halt_i=1 while a load is outstanding → response still delivered next cycle, no new grants, counter frozen; mem_ready_i=0 gives the same grant blocking.
- Async reset mid-read: resetn_i low between clock edges while in RESP_DM → all outputs 0 immediately; no dm_rvalid_o after re-release.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package mem_arb_pkg;

  localparam int STARVE_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESP_IF = 2'd1,
    RESP_DM = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } arb_owner_t;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Counts consecutive fetch losses, saturating at MAX; max_o asks the arbiter
// to force a fetch grant.
module mem_arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int MAX = 4
) (
  input  logic clk_i,
  input  logic resetn_i,
  input  logic inc_i,
  input  logic clr_i,
  output logic max_o
);

  localparam logic [STARVE_CNT_W-1:0] MaxVal = STARVE_CNT_W'(MAX);

  logic [STARVE_CNT_W-1:0] cnt_q, cnt_d;

  // Clear takes precedence so a forced fetch grant always restarts the count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != MaxVal)) begin
      cnt_d = cnt_q + STARVE_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign max_o = (cnt_q == MaxVal);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one data-memory port between instruction fetch and the load/store
// stage, routing each single-cycle read response back to its issuer.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk_i,
  input  logic            resetn_i,
  input  logic            halt_i,
  input  logic            if_req_i,
  input  logic [XLEN-1:0] if_addr_i,
  output logic            if_gnt_o,
  output logic [XLEN-1:0] if_rdata_o,
  output logic            if_rvalid_o,
  input  logic            dm_req_i,
  input  logic            dm_we_i,
  input  logic [XLEN-1:0] dm_addr_i,
  input  logic [XLEN-1:0] dm_wdata_i,
  output logic            dm_gnt_o,
  output logic [XLEN-1:0] dm_rdata_o,
  output logic            dm_rvalid_o,
  input  logic            mem_ready_i,
  output logic [XLEN-1:0] mem_addr_o,
  output logic            mem_read_en_o,
  output logic            mem_write_en_o,
  output logic [XLEN-1:0] mem_write_data_o,
  input  logic [XLEN-1:0] mem_read_data_i
);

  arb_state_t state_q, state_d;
  arb_owner_t winner;
  logic       arbEn_q;
  logic       issueOk;
  logic       starveMax;
  logic       ifGnt, dmGnt;

  assign issueOk = arbEn_q & ~halt_i & mem_ready_i;

  // Data normally wins; a starved fetch overrides it once the counter saturates.
  always_comb begin
    winner = OWN_NONE;
    if (issueOk) begin
      if (if_req_i && starveMax) begin
        winner = OWN_IF;
      end else if (dm_req_i) begin
        winner = OWN_DM;
      end else if (if_req_i) begin
        winner = OWN_IF;
      end
    end
  end

  assign ifGnt    = (winner == OWN_IF);
  assign dmGnt    = (winner == OWN_DM);
  assign if_gnt_o = ifGnt;
  assign dm_gnt_o = dmGnt;

  always_comb begin
    mem_addr_o       = '0;
    mem_read_en_o    = 1'b0;
    mem_write_en_o   = 1'b0;
    mem_write_data_o = '0;
    case (winner)
      OWN_IF: begin
        mem_addr_o    = if_addr_i;
        mem_read_en_o = 1'b1;
      end
      OWN_DM: begin
        mem_addr_o     = dm_addr_i;
        mem_read_en_o  = ~dm_we_i;
        mem_write_en_o = dm_we_i;
        if (dm_we_i) begin
          mem_write_data_o = dm_wdata_i;
        end
      end
      default: ;
    endcase
  end

  // The state only records who owns next cycle's read data; stores and idle
  // cycles leave nothing outstanding.
  always_comb begin
    state_d = IDLE;
    if (ifGnt) begin
      state_d = RESP_IF;
    end else if (dmGnt && !dm_we_i) begin
      state_d = RESP_DM;
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q <= IDLE;
      arbEn_q <= 1'b0;
    end else begin
      state_q <= state_d;
      arbEn_q <= 1'b1;
    end
  end

  mem_arb_starve_ctr #(
    .MAX(STARVE_MAX)
  ) u_starve_ctr (
    .clk_i   (clk_i),
    .resetn_i(resetn_i),
    .inc_i   (if_req_i & ~ifGnt & dmGnt),
    .clr_i   (ifGnt | ~if_req_i),
    .max_o   (starveMax)
  );

  assign if_rvalid_o = (state_q == RESP_IF);
  assign dm_rvalid_o = (state_q == RESP_DM);
  assign if_rdata_o  = if_rvalid_o ? mem_read_data_i : '0;
  assign dm_rdata_o  = dm_rvalid_o ? mem_read_data_i : '0;

endmodule
